// File: rtl/sample_tick_capture.sv
// sample_tick_capture
//   Turns each rising edge of the sampling tick into one request to the
//   converter, captures the returned sample and buffers it in a small FIFO.
//   Ticks that arrive while a request is in flight, or while the FIFO is
//   full, are dropped: they are counted and flagged, never queued.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   tick                level-held sampling flag (rising edges matter)
//   req_val / req_rdy   sample request handshake to the converter
//   resp_msg/val/rdy    sample response handshake from the converter
//   out_msg/val/rdy     FIFO head towards the consumer
//   clr                 clears overrun and drop_count
//   overrun             sticky flag: at least one tick dropped
//   drop_count          dropped ticks, saturating at 255
module sample_tick_capture #(
  parameter int unsigned nbits = 16,
  parameter int unsigned depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  output logic             req_val,
  input  logic             req_rdy,
  input  logic [nbits-1:0] resp_msg,
  input  logic             resp_val,
  output logic             resp_rdy,
  output logic [nbits-1:0] out_msg,
  output logic             out_val,
  input  logic             out_rdy,
  input  logic             clr,
  output logic             overrun,
  output logic [7:0]       drop_count
);

  localparam int unsigned AW = (depth > 1) ? $clog2(depth) : 1;
  localparam int unsigned CW = $clog2(depth) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              tick_q;
  logic              tick_edge;
  logic              fifo_full;
  logic              drop;
  logic              push;
  logic              pop;

  logic [nbits-1:0]  mem_q [depth];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;

  logic              overrun_q, overrun_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  assign tick_edge = tick & ~tick_q;
  // Full check uses the registered count, so a same-cycle pop does not
  // free a slot for a tick arriving in that cycle.
  assign fifo_full = (count_q == CW'(depth));
  assign drop      = tick_edge & ((state_q != S_IDLE) | fifo_full);

  assign req_val   = (state_q == S_REQ);
  assign resp_rdy  = (state_q == S_WAIT);
  assign push      = (state_q == S_WAIT) & resp_val;
  assign out_val   = (count_q != '0);
  assign pop       = out_val & out_rdy;
  assign out_msg   = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (tick_edge && !fifo_full) state_d = S_REQ;
      S_REQ:   if (req_rdy)                 state_d = S_WAIT;
      S_WAIT:  if (resp_val)                state_d = S_IDLE;
      default:                              state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // A drop in the same cycle as clr wins: the counter restarts at one.
  always_comb begin
    overrun_d  = overrun_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overrun_d = 1'b1;
      if (clr)                      drop_cnt_d = 8'd1;
      else if (drop_cnt_q != '1)    drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (clr) begin
      overrun_d  = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tick_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      drop_cnt_q <= drop_cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Storage is not reset; contents are only visible through out_val.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= resp_msg;
  end

  assign overrun    = overrun_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_sample_tick_capture.sv
module tb_sample_tick_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        req_val;
  logic        req_rdy = 1'b0;
  logic [15:0] resp_msg = '0;
  logic        resp_val = 1'b0;
  logic        resp_rdy;
  logic [15:0] out_msg;
  logic        out_val;
  logic        out_rdy = 1'b0;
  logic        clr = 1'b0;
  logic        overrun;
  logic [7:0]  drop_count;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  sample_tick_capture #(.nbits(16), .depth(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .req_val    (req_val),
    .req_rdy    (req_rdy),
    .resp_msg   (resp_msg),
    .resp_val   (resp_val),
    .resp_rdy   (resp_rdy),
    .out_msg    (out_msg),
    .out_val    (out_val),
    .out_rdy    (out_rdy),
    .clr        (clr),
    .overrun    (overrun),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // One full tick service: edge, request accepted, response returned.
  task automatic service(input logic [15:0] d);
    tick = 1'b1;
    step();
    tick = 1'b0;
    req_rdy = 1'b1;
    step();
    req_rdy = 1'b0;
    resp_val = 1'b1;
    resp_msg = d;
    step();
    resp_val = 1'b0;
  endtask

  initial begin
    int unsigned reqs;

    // Reset state
    do_reset();
    check("rst_req_val", req_val, 0);
    check("rst_resp_rdy", resp_rdy, 0);
    check("rst_out_val", out_val, 0);
    check("rst_overrun", overrun, 0);
    check("rst_drop_count", drop_count, 0);

    // Basic capture with minimum latency
    step(); step();
    tick = 1'b1;
    step();
    check("basic_req_val", req_val, 1);
    req_rdy = 1'b1;
    step();
    req_rdy = 1'b0;
    check("basic_req_val_low", req_val, 0);
    check("basic_resp_rdy", resp_rdy, 1);
    check("basic_out_val_early", out_val, 0);
    resp_val = 1'b1;
    resp_msg = 16'h1234;
    step();
    resp_val = 1'b0;
    check("basic_out_val", out_val, 1);
    check("basic_out_msg", out_msg, 16'h1234);
    check("basic_drop_count", drop_count, 0);
    tick = 1'b0;
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    check("basic_popped", out_val, 0);

    // Level tick: one request per rising edge only
    do_reset();
    req_rdy = 1'b1; resp_val = 1'b1; resp_msg = 16'h0005; out_rdy = 1'b1;
    tick = 1'b1;
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (req_val) reqs++;
    end
    check("level_one_req", reqs, 1);
    tick = 1'b0;
    step();
    tick = 1'b1;
    reqs = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (req_val) reqs++;
    end
    check("level_second_req", reqs, 1);
    check("level_no_drop", drop_count, 0);
    tick = 1'b0; req_rdy = 1'b0; resp_val = 1'b0; out_rdy = 1'b0;

    // Full FIFO drop, then in-order drain
    do_reset();
    for (int i = 1; i <= 4; i++) service(16'(i));
    check("full_head", out_msg, 1);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("full_no_req", req_val, 0);
    check("full_overrun", overrun, 1);
    check("full_drop_count", drop_count, 1);
    out_rdy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_val", out_val, 1);
      check("drain_msg", out_msg, i);
      step();
    end
    out_rdy = 1'b0;
    check("drain_empty", out_val, 0);

    // Busy drops while a request is stalled
    do_reset();
    tick = 1'b1; step(); tick = 1'b0; step();
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1; step(); tick = 1'b0; step();
    end
    check("busy_drop_count", drop_count, 3);
    check("busy_req_held", req_val, 1);
    req_rdy = 1'b1; step(); req_rdy = 1'b0;
    resp_val = 1'b1; resp_msg = 16'hBEEF; step(); resp_val = 1'b0;
    check("busy_out_val", out_val, 1);
    check("busy_out_msg", out_msg, 16'hBEEF);
    check("busy_idle", req_val, 0);
    out_rdy = 1'b1; step(); out_rdy = 1'b0;
    check("busy_single_entry", out_val, 0);

    // Saturation and clr
    do_reset();
    tick = 1'b1; step(); tick = 1'b0; step();
    for (int i = 0; i < 300; i++) begin
      tick = 1'b1; step(); tick = 1'b0; step();
    end
    check("sat_drop_count", drop_count, 255);
    check("sat_overrun", overrun, 1);
    clr = 1'b1; step(); clr = 1'b0;
    check("clr_overrun", overrun, 0);
    check("clr_drop_count", drop_count, 0);
    tick = 1'b1; clr = 1'b1; step(); tick = 1'b0; clr = 1'b0;
    check("clr_drop_overrun", overrun, 1);
    check("clr_drop_count1", drop_count, 1);

    // Asynchronous reset mid-WAIT
    do_reset();
    service(16'h00AA);
    check("ar_out_val_pre", out_val, 1);
    tick = 1'b1; step(); tick = 1'b0;
    req_rdy = 1'b1; step(); req_rdy = 1'b0;
    check("ar_in_wait", resp_rdy, 1);
    tick = 1'b1; step(); tick = 1'b0;
    check("ar_drop_pre", drop_count, 1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_resp_rdy", resp_rdy, 0);
    check("ar_req_val", req_val, 0);
    check("ar_out_val", out_val, 0);
    check("ar_overrun", overrun, 0);
    check("ar_drop_count", drop_count, 0);
    step();
    reset = 1'b0;
    resp_val = 1'b1; resp_msg = 16'h5555;
    step(); step(); step();
    resp_val = 1'b0;
    check("ar_resp_ignored", out_val, 0);
    check("ar_still_idle", resp_rdy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
